// File: rtl/apb_byte_master.sv
// APB3 requester driven by a byte command stream; returns a status byte and,
// for reads, a data byte on the response stream. One transfer outstanding at a time.
module apb_byte_master #(
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [2:0]            pprot,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [7:0]            pwdata,
    output logic                  pstrb,
    input  logic                  pready,
    input  logic [7:0]            prdata,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] STATUS_TIMEOUT = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WDATA     = 3'd1,
        S_SETUP     = 3'd2,
        S_ACCESS    = 3'd3,
        S_RESP_STAT = 3'd4,
        S_RESP_DATA = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_paddr,    w_paddr_nxt;
    logic                  r_pwrite,   w_pwrite_nxt;
    logic [7:0]            r_pwdata,   w_pwdata_nxt;
    logic                  r_psel,     w_psel_nxt;
    logic                  r_penable,  w_penable_nxt;
    logic [7:0]            r_out_data, w_out_data_nxt;
    logic [7:0]            r_rdata,    w_rdata_nxt;
    logic [CNT_W-1:0]      r_cnt,      w_cnt_nxt;

    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_timeout_hit;
    logic                  w_unused_in;

    // Command bits between bit7 and the address field carry no meaning.
    assign w_unused_in = &{1'b0, in_data};

    assign w_in_hs       = in_valid && in_ready;
    assign w_out_hs      = out_valid && out_ready;
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                           ((32'(r_cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_state_nxt = in_data[7] ? S_WDATA : S_SETUP;
                end
            end
            S_WDATA: begin
                if (w_in_hs) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready || w_timeout_hit) begin
                    w_state_nxt = S_RESP_STAT;
                end
            end
            S_RESP_STAT: begin
                if (w_out_hs) begin
                    w_state_nxt = r_pwrite ? S_IDLE : S_RESP_DATA;
                end
            end
            S_RESP_DATA: begin
                if (w_out_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode and next values of the registered outputs/datapath
    always_comb begin
        in_ready       = (r_state == S_IDLE) || (r_state == S_WDATA);
        out_valid      = (r_state == S_RESP_STAT) || (r_state == S_RESP_DATA);
        w_paddr_nxt    = r_paddr;
        w_pwrite_nxt   = r_pwrite;
        w_pwdata_nxt   = r_pwdata;
        w_out_data_nxt = r_out_data;
        w_rdata_nxt    = r_rdata;
        w_cnt_nxt      = r_cnt;
        w_psel_nxt     = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
        w_penable_nxt  = (w_state_nxt == S_ACCESS);

        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_paddr_nxt  = in_data[ADDR_WIDTH-1:0];
                    w_pwrite_nxt = in_data[7];
                end
            end
            S_WDATA: begin
                if (w_in_hs) begin
                    w_pwdata_nxt = in_data;
                end
            end
            S_ACCESS: begin
                if (pready) begin
                    // pslverr only has meaning in the completing cycle
                    w_out_data_nxt = {7'b0, pslverr};
                    if (!r_pwrite) begin
                        w_rdata_nxt = prdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_timeout_hit) begin
                        w_out_data_nxt = STATUS_TIMEOUT;
                        w_rdata_nxt    = 8'h00;
                    end
                end
            end
            S_RESP_STAT: begin
                if (w_out_hs && !r_pwrite) begin
                    w_out_data_nxt = r_rdata;
                end
            end
            default: begin
            end
        endcase

        if (w_state_nxt == S_SETUP) begin
            w_cnt_nxt = '0;
        end
    end

    // Datapath and APB output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= 8'h00;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_out_data <= 8'h00;
            r_rdata    <= 8'h00;
            r_cnt      <= '0;
        end else begin
            r_paddr    <= w_paddr_nxt;
            r_pwrite   <= w_pwrite_nxt;
            r_pwdata   <= w_pwdata_nxt;
            r_psel     <= w_psel_nxt;
            r_penable  <= w_penable_nxt;
            r_out_data <= w_out_data_nxt;
            r_rdata    <= w_rdata_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign paddr    = r_paddr;
    assign pwrite   = r_pwrite;
    assign pwdata   = r_pwdata;
    assign psel     = r_psel;
    assign penable  = r_penable;
    assign out_data = r_out_data;
    assign pprot    = 3'b000;
    assign pstrb    = 1'b1;

endmodule

// File: tb/tb_apb_byte_master.sv
// Directed bench for apb_byte_master: one task per scenario, inline checks,
// plus a second instance with the timeout disabled.
module tb_apb_byte_master;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] paddr, pprot;
    logic       psel, penable, pwrite, pstrb, pready, pslverr;
    logic [7:0] pwdata, prdata;

    logic       nt_in_valid, nt_in_ready, nt_out_valid, nt_out_ready;
    logic [7:0] nt_in_data, nt_out_data;
    logic [2:0] nt_paddr, nt_pprot;
    logic       nt_psel, nt_penable, nt_pwrite, nt_pstrb, nt_pready, nt_pslverr;
    logic [7:0] nt_pwdata, nt_prdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_byte_master #(.ADDR_WIDTH(3), .TIMEOUT_CYCLES(15)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    apb_byte_master #(.ADDR_WIDTH(3), .TIMEOUT_CYCLES(0)) u_dut_nt (
        .clk(clk), .rst(rst),
        .in_valid(nt_in_valid), .in_ready(nt_in_ready), .in_data(nt_in_data),
        .out_valid(nt_out_valid), .out_ready(nt_out_ready), .out_data(nt_out_data),
        .paddr(nt_paddr), .pprot(nt_pprot), .psel(nt_psel), .penable(nt_penable),
        .pwrite(nt_pwrite), .pwdata(nt_pwdata), .pstrb(nt_pstrb),
        .pready(nt_pready), .prdata(nt_prdata), .pslverr(nt_pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (psel !== 1'b0)      begin errors++; $display("FAIL rst_psel got=%b exp=0", psel); end
        checks++; if (penable !== 1'b0)   begin errors++; $display("FAIL rst_penable got=%b exp=0", penable); end
        checks++; if (pwrite !== 1'b0)    begin errors++; $display("FAIL rst_pwrite got=%b exp=0", pwrite); end
        checks++; if (paddr !== 3'd0)     begin errors++; $display("FAIL rst_paddr got=%h exp=0", paddr); end
        checks++; if (pwdata !== 8'h00)   begin errors++; $display("FAIL rst_pwdata got=%h exp=00", pwdata); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (pprot !== 3'b000 || pstrb !== 1'b1) begin errors++; $display("FAIL rst_const got=%b/%b exp=000/1", pprot, pstrb); end
    endtask

    task automatic test_write_read();
        pready = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h85;
        tick();
        checks++; if (in_ready !== 1'b1 || psel !== 1'b0) begin errors++; $display("FAIL wr_wdata got in_ready=%b psel=%b exp=1/0", in_ready, psel); end
        in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        checks++; if (psel !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL wr_setup got psel=%b penable=%b exp=1/0", psel, penable); end
        checks++; if (paddr !== 3'd5 || pwrite !== 1'b1 || pwdata !== 8'hA5) begin errors++; $display("FAIL wr_setup_bus got addr=%h wr=%b wd=%h exp=5/1/a5", paddr, pwrite, pwdata); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wr_setup_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (psel !== 1'b1 || penable !== 1'b1) begin errors++; $display("FAIL wr_access got psel=%b penable=%b exp=1/1", psel, penable); end
        tick();
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL wr_done got psel=%b penable=%b exp=0/0", psel, penable); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL wr_status got v=%b d=%h exp=1/00", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL wr_idle got v=%b rdy=%b exp=0/1", out_valid, in_ready); end

        prdata = 8'hA5;
        in_valid = 1'b1; in_data = 8'h05;
        tick();
        in_valid = 1'b0;
        checks++; if (psel !== 1'b1 || pwrite !== 1'b0 || paddr !== 3'd5) begin errors++; $display("FAIL rd_setup got psel=%b wr=%b addr=%h exp=1/0/5", psel, pwrite, paddr); end
        tick();
        checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rd_access got penable=%b exp=1", penable); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL rd_status got v=%b d=%h exp=1/00", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL rd_data got v=%b d=%h exp=1/a5", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rd_idle got v=%b rdy=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_wait_states();
        pready = 1'b0;
        in_valid = 1'b1; in_data = 8'h83;
        tick();
        in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 3'd3 || pwdata !== 8'h5A || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ws_hold cyc=%0d got psel=%b en=%b addr=%h wd=%h rdy=%b exp=1/1/3/5a/0", i, psel, penable, paddr, pwdata, in_ready);
            end
            if (i == 3) pready = 1'b1;
            tick();
        end
        checks++; if (psel !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL ws_done got psel=%b v=%b d=%h exp=0/1/00", psel, out_valid, out_data); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ws_idle got rdy=%b exp=1", in_ready); end
    endtask

    task automatic test_slave_error();
        pready = 1'b1; pslverr = 1'b1; prdata = 8'h3C;
        in_valid = 1'b1; in_data = 8'h02;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin errors++; $display("FAIL err_status got v=%b d=%h exp=1/01", out_valid, out_data); end
        pslverr = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL err_data got v=%b d=%h exp=1/3c", out_valid, out_data); end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        pready = 1'b0; prdata = 8'hEE;
        in_valid = 1'b1; in_data = 8'h07;
        tick();
        in_valid = 1'b0;
        tick();
        n = 0;
        while (psel === 1'b1 && penable === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++; if (n != 15) begin errors++; $display("FAIL to_cycles got=%0d exp=15", n); end
        checks++; if (psel !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h02) begin errors++; $display("FAIL to_status got psel=%b v=%b d=%h exp=0/1/02", psel, out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL to_data got v=%b d=%h exp=1/00", out_valid, out_data); end
        tick();
        pready = 1'b1;
    endtask

    task automatic test_back_pressure();
        pready = 1'b1; prdata = 8'h77; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_data = 8'h86;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h00 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b exp=1/00/0", i, out_valid, out_data, in_ready);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin errors++; $display("FAIL bp_data got v=%b d=%h exp=1/77", out_valid, out_data); end
        tick();
        checks++; if (in_ready !== 1'b1 || paddr !== 3'd1 || pwrite !== 1'b0) begin errors++; $display("FAIL bp_no_consume got rdy=%b addr=%h wr=%b exp=1/1/0", in_ready, paddr, pwrite); end
    endtask

    task automatic test_reset_mid_access();
        pready = 1'b0;
        in_valid = 1'b1; in_data = 8'h04;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rma_pre got penable=%b exp=1", penable); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || paddr !== 3'd0) begin
            errors++;
            $display("FAIL rma_reset got psel=%b en=%b rdy=%b v=%b addr=%h exp=0/0/1/0/0", psel, penable, in_ready, out_valid, paddr);
        end
        pready = 1'b1; prdata = 8'h99;
        in_valid = 1'b1; in_data = 8'h06;
        tick();
        in_valid = 1'b0;
        checks++; if (psel !== 1'b1 || paddr !== 3'd6) begin errors++; $display("FAIL rma_setup got psel=%b addr=%h exp=1/6", psel, paddr); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL rma_status got v=%b d=%h exp=1/00", out_valid, out_data); end
        tick();
        checks++; if (out_data !== 8'h99) begin errors++; $display("FAIL rma_data got d=%h exp=99", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rma_idle got v=%b rdy=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_no_timeout();
        int held;
        nt_in_valid = 1'b1; nt_in_data = 8'h03;
        tick();
        nt_in_valid = 1'b0;
        tick();
        held = 0;
        for (int i = 0; i < 40; i++) begin
            if (nt_psel === 1'b1 && nt_penable === 1'b1) held++;
            tick();
        end
        checks++; if (held != 40) begin errors++; $display("FAIL nt_held got=%0d exp=40", held); end
        nt_pready = 1'b1;
        tick();
        checks++; if (nt_psel !== 1'b0 || nt_out_valid !== 1'b1 || nt_out_data !== 8'h00) begin
            errors++;
            $display("FAIL nt_done got psel=%b v=%b d=%h exp=0/1/00", nt_psel, nt_out_valid, nt_out_data);
        end
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        pready = 1'b1; prdata = 8'h00; pslverr = 1'b0;
        nt_in_valid = 1'b0; nt_in_data = 8'h00; nt_out_ready = 1'b1;
        nt_pready = 1'b0; nt_prdata = 8'h00; nt_pslverr = 1'b0;

        test_reset();
        test_write_read();
        test_wait_states();
        test_slave_error();
        test_timeout();
        test_back_pressure();
        test_reset_mid_access();
        test_no_timeout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_byte_master.md
Name: apb_byte_master

Overview:
- Upstream APB requester for the on-chip byte-wide register slave.
- Accepts a byte command stream over a valid/ready interface and decodes each command into one APB3 read or write transfer.
- Returns status and read data as a byte response stream.
- Sits between the pin/serial front end and the APB slave.

Parameters:
- ADDR_WIDTH, 3, APB address width. Legal range 1..7. Taken from cmd[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 15, number of consecutive ACCESS cycles without pready before the transfer is aborted. 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  command/data byte valid
- in_ready  output  1  block accepts a byte
- in_data  input  8  command or write-data byte
- out_valid  output  1  response byte valid
- out_ready  input  1  consumer accepts the response byte
- out_data  output  8  response byte
- paddr  output  ADDR_WIDTH  APB address
- pprot  output  3  constant 3'b000
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- pwdata  output  8  APB write data
- pstrb  output  1  constant 1'b1
- pready  input  1  slave ready
- prdata  input  8  slave read data
- pslverr  input  1  slave error

Behaviour:
- Byte handshake: a transfer occurs on any edge where valid && ready.
  - in_ready is high only in IDLE and WDATA.
  - out_valid is high only in RESP_STAT and RESP_DATA.
- Command byte format:
  - bit7 = write (1) / read (0).
  - bits[ADDR_WIDTH-1:0] = address.
  - Remaining bits are ignored.
- All outputs are registered except in_ready/out_valid, which are decoded from registered state.
- Reset: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, out_data=0, timeout counter=0, captured status/data=0.
- States:
  - IDLE: on command handshake, latch address and write bit.
    - Write command -> WDATA.
    - Read command -> SETUP.
  - WDATA: on handshake, latch pwdata -> SETUP.
  - SETUP: psel=1, penable=0 for exactly one cycle -> ACCESS.
  - ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
    - pready=1: capture prdata (reads only), status = {7'b0, pslverr}; drop psel/penable -> RESP_STAT.
    - pready=0: increment counter. When TIMEOUT_CYCLES (nonzero) consecutive ACCESS cycles have had pready=0, drop psel/penable, status=8'h02, captured data=8'h00 -> RESP_STAT.
  - RESP_STAT: out_data=status; hold until out_ready.
    - On handshake: read -> RESP_DATA; write -> IDLE.
  - RESP_DATA: out_data = captured read data; on handshake -> IDLE.
- Timeout counter clears on entry to SETUP.
- pslverr is sampled only when pready=1.
- Latency, read with immediate pready and out_ready held high:
  - Command accepted at edge T.
  - SETUP during T..T+1, ACCESS during T+1..T+2.
  - Status valid after T+2, data byte valid after T+3.
  - Next command accepted after T+4.
- A write adds one cycle per data-byte handshake.
- Back-pressure: out_valid/out_data stay stable while out_ready=0. No new command is accepted until the response completes, so at most one transaction is outstanding.
- in_valid is ignored outside IDLE/WDATA; no byte is consumed there.
- Reset asserted mid-transaction: next edge forces IDLE with psel=penable=0. Partial command and pending response are discarded.

Test Plan:
- Write then read: in 8'h85, 8'hA5; slave pready=1 -> one SETUP cycle then one ACCESS cycle with paddr=5, pwrite=1, pwdata=A5; response 8'h00. Then in 8'h05, prdata=A5 -> responses 8'h00, 8'hA5.
- Wait states: pready low for 3 ACCESS cycles -> psel/penable held, paddr/pwdata stable; completes on the 4th cycle; in_ready=0 throughout.
- Slave error: read with pready=1, pslverr=1, prdata=3C -> responses 8'h01, 8'h3C.
- Timeout: pready tied 0, TIMEOUT_CYCLES=15 -> exactly 15 ACCESS cycles, then psel=0; responses 8'h02, 8'h00. With TIMEOUT_CYCLES=0, ACCESS is held indefinitely.
- Back-pressure: out_ready=0 for 5 cycles during RESP_STAT -> out_valid/out_data stable; a concurrent in_valid byte is not consumed.
- Reset mid-ACCESS: rst pulse for one cycle -> psel=penable=0 and state IDLE on the next edge; a following read command completes normally.
